// File: rtl/div_pkg.sv
// Shared definitions for the bitslice divider: default operand width and
// the requester state encoding.
package div_pkg;
    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RELEASE,
        RESULT
    } div_req_state_t;
endpackage

// File: rtl/div_timeout_ctr.sv
// Watchdog counter for the Req phase: expired is high once TIMEOUT-1 cycles
// have been counted since the last clear.
module div_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + CW'(1);
    end

    assign expired = (count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/div_requester.sv
// Initiator side of the divider Req/Done 4-phase handshake, with host
// valid/ready channels, local divide-by-zero handling and a stall timeout.
module div_requester
    import div_pkg::*;
#(
    parameter int WIDTH   = DIV_WIDTH,
    parameter int TIMEOUT = 64
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InDividend,
    input  logic [WIDTH-1:0] InDivisor,
    output logic [WIDTH-1:0] Dividend,
    output logic [WIDTH-1:0] Divisor,
    output logic             Req,
    input  logic             Done,
    input  logic [WIDTH-1:0] Quotient,
    input  logic [WIDTH-1:0] Remainder,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutQuotient,
    output logic [WIDTH-1:0] OutRemainder,
    output logic             OutDivZero,
    output logic             OutTimeout,
    output logic             Busy
);
    div_req_state_t state;
    logic           expired;

    div_timeout_ctr #(.TIMEOUT(TIMEOUT)) uTimeout (
        .Clock  (Clock),
        .Reset  (Reset),
        .clear  (state == IDLE),
        .enable (state == REQ),
        .expired(expired)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            InReady      <= 1'b1;
            Req          <= 1'b0;
            OutValid     <= 1'b0;
            OutDivZero   <= 1'b0;
            OutTimeout   <= 1'b0;
            Busy         <= 1'b0;
            Dividend     <= '0;
            Divisor      <= '0;
            OutQuotient  <= '0;
            OutRemainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (InValid) begin
                        Dividend <= InDividend;
                        Divisor  <= InDivisor;
                        InReady  <= 1'b0;
                        Busy     <= 1'b1;
                        // Zero divisor never reaches the datapath.
                        if (InDivisor == '0) begin
                            OutQuotient  <= '1;
                            OutRemainder <= InDividend;
                            OutDivZero   <= 1'b1;
                            OutValid     <= 1'b1;
                            state        <= RESULT;
                        end else begin
                            Req   <= 1'b1;
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (Done) begin
                        OutQuotient  <= Quotient;
                        OutRemainder <= Remainder;
                        Req          <= 1'b0;
                        state        <= RELEASE;
                    end else if (expired) begin
                        OutQuotient  <= '0;
                        OutRemainder <= '0;
                        OutTimeout   <= 1'b1;
                        Req          <= 1'b0;
                        state        <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Wait for the responder to drop Done before reporting.
                    if (!Done) begin
                        OutValid <= 1'b1;
                        state    <= RESULT;
                    end
                end
                RESULT: begin
                    if (OutReady) begin
                        OutValid   <= 1'b0;
                        OutDivZero <= 1'b0;
                        OutTimeout <= 1'b0;
                        InReady    <= 1'b1;
                        Busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_requester.sv
// Directed bench for div_requester with a small Req/Done responder.
module tb_div_requester;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 64;

    logic             Clock = 1'b0;
    logic             Reset = 1'b1;
    logic             InValid = 1'b0;
    logic             InReady;
    logic [WIDTH-1:0] InDividend = '0;
    logic [WIDTH-1:0] InDivisor = '0;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
    logic             Req;
    logic             Done = 1'b0;
    logic [WIDTH-1:0] Quotient = '0;
    logic [WIDTH-1:0] Remainder = '0;
    logic             OutValid;
    logic             OutReady = 1'b0;
    logic [WIDTH-1:0] OutQuotient;
    logic [WIDTH-1:0] OutRemainder;
    logic             OutDivZero;
    logic             OutTimeout;
    logic             Busy;

    int nChecks = 0;
    int nPass   = 0;

    div_requester #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .Reset(Reset),
        .InValid(InValid), .InReady(InReady),
        .InDividend(InDividend), .InDivisor(InDivisor),
        .Dividend(Dividend), .Divisor(Divisor),
        .Req(Req), .Done(Done), .Quotient(Quotient), .Remainder(Remainder),
        .OutValid(OutValid), .OutReady(OutReady),
        .OutQuotient(OutQuotient), .OutRemainder(OutRemainder),
        .OutDivZero(OutDivZero), .OutTimeout(OutTimeout), .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Issue one job and play the responder. doneAfter=0 means never raise Done.
    task automatic runJob(input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs,
                          input int doneAfter, input logic [WIDTH-1:0] q,
                          input logic [WIDTH-1:0] r, input int releaseDelay,
                          output int reqCycles, output int waitCycles);
        InDividend = dvd;
        InDivisor  = dvs;
        InValid    = 1'b1;
        tick();
        InValid   = 1'b0;
        reqCycles = 0;
        for (int i = 0; i < 200; i++) begin
            if (!Req) break;
            reqCycles++;
            if (reqCycles == doneAfter) begin
                Done      = 1'b1;
                Quotient  = q;
                Remainder = r;
            end
            tick();
        end
        for (int i = 0; i < releaseDelay; i++) begin
            tick();
            chk("outValidDuringRelease", OutValid, 0);
        end
        Done = 1'b0;
        waitCycles = 0;
        while (!OutValid && waitCycles < 100) begin
            tick();
            waitCycles++;
        end
    endtask

    task automatic consume();
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
        chk("inReadyAfterConsume", InReady, 1);
        chk("outValidAfterConsume", OutValid, 0);
        chk("busyAfterConsume", Busy, 0);
    endtask

    initial begin
        int rc, wc;
        #12;
        Reset = 1'b0;
        tick();
        chk("rstInReady", InReady, 1);
        chk("rstReq", Req, 0);
        chk("rstOutValid", OutValid, 0);
        chk("rstBusy", Busy, 0);
        chk("rstData", {Dividend, Divisor, OutQuotient, OutRemainder}, 0);
        chk("rstFlags", {OutDivZero, OutTimeout}, 0);

        // Normal job 200/7
        runJob(8'd200, 8'd7, 9, 8'd28, 8'd4, 1, rc, wc);
        chk("normReqCycles", rc, 9);
        chk("normWait", wc, 1);
        chk("normQ", OutQuotient, 28);
        chk("normR", OutRemainder, 4);
        chk("normFlags", {OutDivZero, OutTimeout}, 0);
        chk("normOperands", {Dividend, Divisor}, {8'd200, 8'd7});
        chk("normInReady", InReady, 0);
        consume();

        // Divide by zero 55/0
        runJob(8'd55, 8'd0, 0, 8'd0, 8'd0, 0, rc, wc);
        chk("dzReqCycles", rc, 0);
        chk("dzWait", wc, 0);
        chk("dzQ", OutQuotient, 255);
        chk("dzR", OutRemainder, 55);
        chk("dzFlags", {OutDivZero, OutTimeout}, 2'b10);
        consume();

        // Timeout: Done never raised
        runJob(8'd77, 8'd3, 0, 8'd0, 8'd0, 0, rc, wc);
        chk("toReqCycles", rc, TIMEOUT);
        chk("toWait", wc, 1);
        chk("toQR", {OutQuotient, OutRemainder}, 0);
        chk("toFlags", {OutDivZero, OutTimeout}, 2'b01);
        consume();

        // Slow release then back-pressure: 150/12 -> 12 r 6
        runJob(8'd150, 8'd12, 3, 8'd12, 8'd6, 5, rc, wc);
        chk("bpReqCycles", rc, 3);
        chk("bpWait", wc, 1);
        for (int i = 0; i < 10; i++) begin
            Done     = (i == 4);
            Quotient = 8'd99;
            tick();
            chk("bpHold", {OutValid, InReady, OutQuotient, OutRemainder},
                {1'b1, 1'b0, 8'd12, 8'd6});
        end
        Done = 1'b0;
        consume();

        // Stray Done in IDLE must not disturb anything
        Done      = 1'b1;
        Quotient  = 8'd99;
        Remainder = 8'd98;
        tick();
        tick();
        Done = 1'b0;
        chk("strayDone", {OutValid, Req, InReady, OutQuotient, OutRemainder},
            {1'b0, 1'b0, 1'b1, 8'd12, 8'd6});

        // Reset mid-REQ
        InDividend = 8'd9;
        InDivisor  = 8'd2;
        InValid    = 1'b1;
        tick();
        InValid = 1'b0;
        tick();
        chk("midReqHigh", Req, 1);
        #2 Reset = 1'b1;
        #1;
        chk("asyncReqDrop", Req, 0);
        chk("asyncIdle", {InReady, Busy, OutValid}, 3'b100);
        #1 Reset = 1'b0;
        tick();

        runJob(8'd100, 8'd10, 4, 8'd10, 8'd0, 1, rc, wc);
        chk("postRstReqCycles", rc, 4);
        chk("postRstWait", wc, 1);
        chk("postRstQR", {OutQuotient, OutRemainder}, {8'd10, 8'd0});
        chk("postRstFlags", {OutDivZero, OutTimeout}, 0);
        consume();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
